// File: rtl/regfile.sv
// RV32I integer register file: x1..x31 storage, two combinational read ports, one synchronous write port.
// Define REGFILE_BYPASS_EN to forward the same-cycle write data to a matching read port.
module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    // x0 has no storage; entries exist only for x1..x(NUM_REGS-1)
    logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];
    logic [DATA_W-1:0] w_stored1;
    logic [DATA_W-1:0] w_stored2;
    logic              w_hit1;
    logic              w_hit2;
    logic              w_wrEn;

    assign w_wrEn = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_wrEn && (waddr == ADDR_W'(i))) begin
                    r_regs[i] <= wdata;
                end
            end
        end
    end

    // Decoded lookup keeps every index in range, including raddr = 0
    always_comb begin
        w_stored1 = '0;
        w_stored2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (raddr1 == ADDR_W'(i)) begin
                w_stored1 = r_regs[i];
            end
            if (raddr2 == ADDR_W'(i)) begin
                w_stored2 = r_regs[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign w_hit1 = we && (waddr == raddr1);
    assign w_hit2 = we && (waddr == raddr2);
`else
    assign w_hit1 = 1'b0;
    assign w_hit2 = 1'b0;
`endif

    always_comb begin
        rdata1 = '0;
        if (rst && re1 && (raddr1 != '0)) begin
            rdata1 = w_hit1 ? wdata : w_stored1;
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst && re2 && (raddr2 != '0)) begin
            rdata2 = w_hit2 ? wdata : w_stored2;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus a randomized run against an array model.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    logic [31:0] model [32];
    int          nChecks;
    int          nPass;

    regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural view of a read port given the current inputs
    function automatic logic [31:0] expRead(input logic ren, input logic [4:0] ra);
        if (!rst || !ren || ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == ra) return wdata;
`endif
        return model[ra];
    endfunction

    // Commit the current inputs to the model, then advance past one rising edge
    task automatic tick();
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && waddr != 5'd0) begin
            model[waddr] = wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        re1 = 1'b0; re2 = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;
        tick();
        we = 1'b0; rst = 1'b0; re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd5; raddr2 = 5'd5;
        #1;
        nChecks++;
        if (rdata1 !== 32'h0) $display("[TB] FAIL reset_rdata1_during: got %h expected %h", rdata1, 32'h0);
        else nPass++;
        nChecks++;
        if (rdata2 !== 32'h0) $display("[TB] FAIL reset_rdata2_during: got %h expected %h", rdata2, 32'h0);
        else nPass++;
        tick();
        rst = 1'b1;
        #1;
        nChecks++;
        if (rdata1 !== 32'h0) $display("[TB] FAIL reset_clear_x5: got %h expected %h", rdata1, 32'h0);
        else nPass++;
    endtask

    task automatic test_x0();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        tick();
        we = 1'b0; re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        nChecks++;
        if (rdata1 !== 32'h0) $display("[TB] FAIL x0_port1: got %h expected %h", rdata1, 32'h0);
        else nPass++;
        nChecks++;
        if (rdata2 !== 32'h0) $display("[TB] FAIL x0_port2: got %h expected %h", rdata2, 32'h0);
        else nPass++;
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 5'd1; wdata = 32'h00000011;
        tick();
        waddr = 5'd31; wdata = 32'h80000000;
        tick();
        we = 1'b0; re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd1; raddr2 = 5'd31;
        #1;
        nChecks++;
        if (rdata1 !== 32'h00000011) $display("[TB] FAIL wr_x1: got %h expected %h", rdata1, 32'h00000011);
        else nPass++;
        nChecks++;
        if (rdata2 !== 32'h80000000) $display("[TB] FAIL wr_x31: got %h expected %h", rdata2, 32'h80000000);
        else nPass++;
        re2 = 1'b0;
        #1;
        nChecks++;
        if (rdata2 !== 32'h0) $display("[TB] FAIL re2_off: got %h expected %h", rdata2, 32'h0);
        else nPass++;
        nChecks++;
        if (rdata1 !== 32'h00000011) $display("[TB] FAIL re2_off_port1: got %h expected %h", rdata1, 32'h00000011);
        else nPass++;
    endtask

    task automatic test_hazard();
        logic [31:0] expSame;
`ifdef REGFILE_BYPASS_EN
        expSame = 32'h2;
`else
        expSame = 32'h1;
`endif
        we = 1'b1; waddr = 5'd7; wdata = 32'h1; re1 = 1'b0; re2 = 1'b0;
        tick();
        wdata = 32'h2; re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        nChecks++;
        if (rdata1 !== expSame) $display("[TB] FAIL hazard_same_p1: got %h expected %h", rdata1, expSame);
        else nPass++;
        nChecks++;
        if (rdata2 !== expSame) $display("[TB] FAIL hazard_same_p2: got %h expected %h", rdata2, expSame);
        else nPass++;
        tick();
        we = 1'b0;
        #1;
        nChecks++;
        if (rdata1 !== 32'h2) $display("[TB] FAIL hazard_next_p1: got %h expected %h", rdata1, 32'h2);
        else nPass++;
        nChecks++;
        if (rdata2 !== 32'h2) $display("[TB] FAIL hazard_next_p2: got %h expected %h", rdata2, 32'h2);
        else nPass++;
    endtask

    task automatic test_reset_discard();
        rst = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'h0000ABCD;
        tick();
        rst = 1'b1; we = 1'b0; re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd7;
        #1;
        nChecks++;
        if (rdata1 !== 32'h0) $display("[TB] FAIL reset_discard_x3: got %h expected %h", rdata1, 32'h0);
        else nPass++;
        nChecks++;
        if (rdata2 !== 32'h0) $display("[TB] FAIL reset_clears_x7: got %h expected %h", rdata2, 32'h0);
        else nPass++;
    endtask

    task automatic test_random();
        logic [31:0] e1;
        logic [31:0] e2;
        for (int c = 0; c < 10000; c++) begin
            rst    = ($urandom_range(0, 99) != 0);
            we     = ($urandom_range(0, 2) != 0);
            waddr  = 5'($urandom);
            wdata  = $urandom;
            re1    = ($urandom_range(0, 7) != 0);
            re2    = ($urandom_range(0, 7) != 0);
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            #1;
            e1 = expRead(re1, raddr1);
            e2 = expRead(re2, raddr2);
            nChecks++;
            if (rdata1 !== e1) $display("[TB] FAIL rand_p1 cycle %0d addr %0d: got %h expected %h", c, raddr1, rdata1, e1);
            else nPass++;
            nChecks++;
            if (rdata2 !== e2) $display("[TB] FAIL rand_p2 cycle %0d addr %0d: got %h expected %h", c, raddr2, rdata2, e2);
            else nPass++;
            tick();
        end
    endtask

    initial begin
        nChecks = 0;
        nPass   = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        re1 = 1'b0; re2 = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;
        @(posedge clk);
        #1;
        tick();
        test_reset();
        test_x0();
        test_write_read();
        test_hazard();
        test_reset_discard();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
